// File: rtl/bus_arbiter_n.sv
// Single-master bus to NSLAVE req/ack slaves with address decode and error log.
// Optional hung-slave timeout is built when BUS_TIMEOUT_EN is defined.
module bus_arbiter_n #(
  parameter int WIDTH       = 32,
  parameter int NSLAVE      = 3,
  parameter int REGION_BITS = 20,
  parameter int TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     m_req,
  input  logic                     m_write,
  input  logic [WIDTH-1:0]         m_addr,
  input  logic [WIDTH-1:0]         m_wdata,
  output logic                     m_ready,
  output logic [WIDTH-1:0]         m_rdata,
  output logic                     m_err,
  output logic [NSLAVE-1:0]        s_req,
  output logic                     s_write,
  output logic [WIDTH-1:0]         s_addr,
  output logic [WIDTH-1:0]         s_wdata,
  input  logic [NSLAVE*WIDTH-1:0]  s_rdata,
  input  logic [NSLAVE-1:0]        s_ack,
  input  logic                     err_clr,
  output logic                     err_flag,
  output logic [WIDTH-1:0]         err_addr
);

  localparam int SELW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
  localparam int TOPB = REGION_BITS + SELW;
  localparam logic [WIDTH-1:0] AMASK =
    {WIDTH{1'b1}} >> (WIDTH - REGION_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [WIDTH-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [SELW-1:0]   idx_q, idx_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              err_flag_q, err_flag_d;
  logic [WIDTH-1:0]  err_addr_q, err_addr_d;

  logic [SELW-1:0]   sel_idx;
  logic              upper_zero;
  logic              in_range;
  logic              mapped;
  logic              ack_sel;
  logic [WIDTH-1:0]  slave_rdata;
  logic              err_set;

`ifdef BUS_TIMEOUT_EN
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNTW-1:0]   tmo_cnt_q, tmo_cnt_d;
`else
  logic              unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Decode of the incoming request address
  always_comb begin
    sel_idx    = m_addr[REGION_BITS +: SELW];
    upper_zero = ((m_addr >> TOPB) == '0);
    in_range   = (int'(sel_idx) < NSLAVE);
    mapped     = upper_zero && in_range;
  end

  always_comb begin
    ack_sel     = 1'b0;
    slave_rdata = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (idx_q == SELW'(i)) begin
        ack_sel     = s_ack[i];
        slave_rdata = s_rdata[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    err_set    = 1'b0;
`ifdef BUS_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (m_req) begin
          write_d = m_write;
          addr_d  = m_addr;
          wdata_d = m_wdata;
          idx_d   = sel_idx;
          rdata_d = '0;
          if (mapped) begin
            state_d = WAIT;
            err_d   = 1'b0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            state_d    = RESP;
            err_d      = 1'b1;
            err_set    = 1'b1;
            err_addr_d = m_addr;
          end
        end
      end
      WAIT: begin
        if (ack_sel) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = write_q ? '0 : slave_rdata;
        end
`ifdef BUS_TIMEOUT_EN
        // An ack on the final allowed cycle takes priority over expiry
        else if (tmo_cnt_q == CNTW'(TIMEOUT - 1)) begin
          state_d    = RESP;
          err_d      = 1'b1;
          err_set    = 1'b1;
          err_addr_d = addr_q;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    err_flag_d = err_set ? 1'b1 :
                 (err_clr ? 1'b0 : err_flag_q);
  end

  always_comb begin
    m_ready  = (state_q == RESP);
    m_err    = (state_q == RESP) && err_q;
    m_rdata  = ((state_q == RESP) && !err_q) ? rdata_q : '0;
    s_req    = (state_q == WAIT) ? (NSLAVE'(1) << idx_q) : '0;
    s_write  = write_q;
    s_addr   = addr_q & AMASK;
    s_wdata  = wdata_q;
    err_flag = err_flag_q;
    err_addr = err_addr_q;
  end

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: vector table, corner sequences, random vs model.
// Hung-slave expectations follow BUS_TIMEOUT_EN.
module tb_bus_arbiter_n;

  localparam int TMO = 6;

  logic        clk;
  logic        nrst;
  logic        m_req;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [2:0]  s_req;
  logic        s_write;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [95:0] s_rdata;
  logic [2:0]  s_ack;
  logic        err_clr;
  logic        err_flag;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  logic        mdl_flag;
  logic [31:0] mdl_addr;

  bus_arbiter_n #(
    .WIDTH(32), .NSLAVE(3), .REGION_BITS(20), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .nrst(nrst),
    .m_req(m_req), .m_write(m_write),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_write(s_write),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .err_clr(err_clr), .err_flag(err_flag), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] ackd;
    bit          spur;
    logic        err;
    logic [31:0] rdata;
    int          idx;
  } vec_t;

  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Reference decode: each slave owns a 1 MiB window starting at 0
  function automatic int ref_idx(input logic [31:0] a);
    return int'(a / 32'h0010_0000);
  endfunction

  function automatic bit ref_mapped(input logic [31:0] a);
    return ref_idx(a) < 3;
  endfunction

  task automatic chk_outs_zero();
    chk("rst_m_ready", 32'(m_ready), 0);
    chk("rst_m_err", 32'(m_err), 0);
    chk("rst_m_rdata", m_rdata, 0);
    chk("rst_s_req", 32'(s_req), 0);
    chk("rst_s_write", 32'(s_write), 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wdata", s_wdata, 0);
    chk("rst_err_flag", 32'(err_flag), 0);
    chk("rst_err_addr", err_addr, 0);
  endtask

  task automatic run_txn(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay,
                         input logic [31:0] ackd, input bit spur,
                         input logic exp_err, input logic [31:0] exp_rd,
                         input int exp_idx);
    logic [2:0] exp_sreq;
    m_req   = 1'b1;
    m_write = wr;
    m_addr  = addr;
    m_wdata = wdata;
    step();
    m_req   = 1'b0;
    m_write = ~wr;
    m_addr  = $urandom;
    m_wdata = $urandom;
    if (exp_err) begin
      mdl_flag = 1'b1;
      mdl_addr = addr;
      chk("unm_ready", 32'(m_ready), 1);
      chk("unm_err", 32'(m_err), 1);
      chk("unm_rdata", m_rdata, 0);
      chk("unm_s_req", 32'(s_req), 0);
      chk("unm_err_flag", 32'(err_flag), 32'(mdl_flag));
      chk("unm_err_addr", err_addr, mdl_addr);
      step();
      chk("unm_ready_drop", 32'(m_ready), 0);
    end else begin
      exp_sreq = 3'b001 << exp_idx;
      for (int w = 0; w <= delay; w++) begin
        chk("wait_s_req", 32'(s_req), 32'(exp_sreq));
        chk("wait_ready", 32'(m_ready), 0);
        if (w == 0) begin
          chk("s_addr", s_addr, addr & 32'h000F_FFFF);
          chk("s_write", 32'(s_write), 32'(wr));
          chk("s_wdata", s_wdata, wdata);
        end
        s_ack   = 3'b000;
        s_rdata = {$urandom, $urandom, $urandom};
        if (w == delay) begin
          s_ack[exp_idx] = 1'b1;
          s_rdata[exp_idx*32 +: 32] = ackd;
        end else if (spur) begin
          s_ack[(exp_idx + 1) % 3] = 1'b1;
        end
        step();
      end
      s_ack = 3'($urandom);
      chk("resp_ready", 32'(m_ready), 1);
      chk("resp_err", 32'(m_err), 0);
      chk("resp_rdata", m_rdata, exp_rd);
      chk("resp_s_req", 32'(s_req), 0);
      chk("resp_err_flag", 32'(err_flag), 32'(mdl_flag));
      chk("resp_err_addr", err_addr, mdl_addr);
      step();
      s_ack = 3'b000;
      chk("resp_ready_drop", 32'(m_ready), 0);
      chk("idle_s_req", 32'(s_req), 0);
    end
  endtask

  initial begin
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] ad;
    int          dl;
    int          ready_seen;
    int          waits;

    nrst     = 1'b0;
    m_req    = 1'b0;
    m_write  = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    s_rdata  = '0;
    s_ack    = '0;
    err_clr  = 1'b0;
    mdl_flag = 1'b0;
    mdl_addr = '0;

    tbl[0] = '{1'b0, 32'h0010_0040, 32'h0, 0, 32'hCAFE_0001, 1'b0,
               1'b0, 32'hCAFE_0001, 1};
    tbl[1] = '{1'b1, 32'h0000_0008, 32'h1234_5678, 5, 32'hDEAD_BEEF,
               1'b0, 1'b0, 32'h0, 0};
    tbl[2] = '{1'b0, 32'h0030_0000, 32'h0, 0, 32'h0, 1'b0,
               1'b1, 32'h0, 0};
    tbl[3] = '{1'b0, 32'h0020_0010, 32'h0, 2, 32'hA5A5_A5A5, 1'b1,
               1'b0, 32'hA5A5_A5A5, 2};
    tbl[4] = '{1'b0, 32'h8000_0000, 32'h0, 0, 32'h0, 1'b0,
               1'b1, 32'h0, 0};
    tbl[5] = '{1'b1, 32'h002F_FFFC, 32'h0BAD_F00D, 1, 32'h5555_5555,
               1'b1, 1'b0, 32'h0, 2};
    tbl[6] = '{1'b0, 32'h0040_0000, 32'h0, 0, 32'h0, 1'b0,
               1'b1, 32'h0, 0};
    tbl[7] = '{1'b0, 32'h000F_FFFF, 32'h0, 3, 32'h0F0F_1234, 1'b1,
               1'b0, 32'h0F0F_1234, 0};

    step();
    step();
    chk_outs_zero();
    nrst = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].delay,
              tbl[i].ackd, tbl[i].spur, tbl[i].err, tbl[i].rdata,
              tbl[i].idx);
    end

    // Clear keeps the address; clear coinciding with a new error loses
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    mdl_flag = 1'b0;
    chk("clr_flag", 32'(err_flag), 0);
    chk("clr_addr_kept", err_addr, mdl_addr);
    m_req   = 1'b1;
    m_addr  = 32'h0031_0000;
    err_clr = 1'b1;
    step();
    m_req   = 1'b0;
    err_clr = 1'b0;
    mdl_flag = 1'b1;
    mdl_addr = 32'h0031_0000;
    chk("set_wins_ready", 32'(m_ready), 1);
    chk("set_wins_flag", 32'(err_flag), 1);
    chk("set_wins_addr", err_addr, 32'h0031_0000);
    step();

    // Back-to-back: held request re-accepted in the IDLE after RESP
    m_req  = 1'b1;
    m_addr = 32'h0030_0004;
    step();
    chk("b2b_ready0", 32'(m_ready), 1);
    step();
    chk("b2b_idle", 32'(m_ready), 0);
    step();
    chk("b2b_ready1", 32'(m_ready), 1);
    m_req = 1'b0;
    mdl_addr = 32'h0030_0004;
    step();
    chk("b2b_drop", 32'(m_ready), 0);

    // Reset in the middle of a WAIT
    m_req  = 1'b1;
    m_write = 1'b1;
    m_addr = 32'h0020_0000;
    m_wdata = 32'h1111_2222;
    step();
    m_req = 1'b0;
    step();
    chk("pre_rst_s_req", 32'(s_req), 32'b100);
    nrst = 1'b0;
    step();
    chk_outs_zero();
    mdl_flag = 1'b0;
    mdl_addr = '0;
    nrst = 1'b1;
    step();
    run_txn(1'b0, 32'h0020_0100, 32'h0, 1, 32'h7777_8888, 1'b0,
            1'b0, 32'h7777_8888, 2);

    // Slave 0 never acknowledges
    m_req   = 1'b1;
    m_write = 1'b0;
    m_addr  = 32'h0000_0100;
    step();
    m_req = 1'b0;
`ifdef BUS_TIMEOUT_EN
    waits = 0;
    for (int c = 0; c < 50 && m_ready !== 1'b1; c++) begin
      if (s_req === 3'b001) waits++;
      step();
    end
    mdl_flag = 1'b1;
    mdl_addr = 32'h0000_0100;
    chk("tmo_waits", 32'(waits), 32'(TMO));
    chk("tmo_ready", 32'(m_ready), 1);
    chk("tmo_err", 32'(m_err), 1);
    chk("tmo_rdata", m_rdata, 0);
    chk("tmo_s_req", 32'(s_req), 0);
    chk("tmo_flag", 32'(err_flag), 1);
    chk("tmo_addr", err_addr, mdl_addr);
    step();
`else
    ready_seen = 0;
    waits = 0;
    for (int c = 0; c < 1000; c++) begin
      if (m_ready === 1'b1) ready_seen++;
      if (s_req === 3'b001) waits++;
      step();
    end
    chk("hang_no_ready", 32'(ready_seen), 0);
    chk("hang_s_req_held", 32'(waits), 1000);
    s_ack = 3'b001;
    s_rdata[31:0] = 32'h0000_0077;
    step();
    s_ack = 3'b000;
    chk("hang_late_ready", 32'(m_ready), 1);
    chk("hang_late_rdata", m_rdata, 32'h0000_0077);
    step();
`endif

    // Random traffic against the reference model
    for (int n = 0; n < 200; n++) begin
      int region;
      region = int'($urandom_range(0, 4));
      if (region == 4) a = $urandom;
      else a = (32'(region) << 20) | 32'($urandom_range(0, 20'hFFFFF));
      wr = 1'($urandom);
      wd = $urandom;
      ad = $urandom;
      dl = int'($urandom_range(0, TMO - 1));
      run_txn(wr, a, wd, dl, ad, 1'($urandom), !ref_mapped(a),
              wr ? 32'h0 : ad, ref_mapped(a) ? ref_idx(a) : 0);
      if ($urandom_range(0, 3) == 0) begin
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        mdl_flag = 1'b0;
        chk("rnd_clr", 32'(err_flag), 0);
        chk("rnd_clr_addr", err_addr, mdl_addr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_n.md
Name: bus_arbiter_n

Overview:
- Parametrised successor to the fixed three-slave data bus between the RISC-V core and its memory-mapped slaves (RAM, dual-port RAM, button).
- Single master; NSLAVE slaves with a request/acknowledge handshake, so each slave may take any number of cycles.
- Registers the master request, decodes the slave index from address bits, and returns read data with a ready pulse.
- Unmapped accesses and hung slaves return an error response and are recorded in a sticky error register.

Parameters:
- WIDTH, 32: data and address width.
- NSLAVE, 3: number of slaves, 1..16.
- REGION_BITS, 20: log2 of the byte window per slave. Slave index = m_addr[REGION_BITS+SELW-1:REGION_BITS], where SELW = max(1, clog2(NSLAVE)).
- TIMEOUT, 255: maximum WAIT cycles before an error response. Used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  single clock.
- nrst  in  1  reset, synchronous, active-low.
- m_req  in  1  master request, sampled in IDLE only.
- m_write  in  1  1 = write, 0 = read.
- m_addr  in  WIDTH  byte address.
- m_wdata  in  WIDTH  write data.
- m_ready  out  1  one-cycle completion pulse.
- m_rdata  out  WIDTH  read data, valid with m_ready.
- m_err  out  1  error response, valid with m_ready.
- s_req  out  NSLAVE  one-hot slave request.
- s_write  out  1  latched m_write.
- s_addr  out  WIDTH  latched m_addr[REGION_BITS-1:0], zero-extended.
- s_wdata  out  WIDTH  latched m_wdata.
- s_rdata  in  NSLAVE*WIDTH  slave i read data at [i*WIDTH +: WIDTH].
- s_ack  in  NSLAVE  slave i acknowledge.
- err_clr  in  1  clears the sticky error.
- err_flag  out  1  sticky error.
- err_addr  out  WIDTH  address of the most recent error.

Behaviour:
- Reset (nrst=0 at a clk edge):
  - state=IDLE.
  - All outputs 0: m_ready, m_err, m_rdata, s_req, s_write, s_addr, s_wdata, err_flag, err_addr.
  - Timeout counter 0.
  - Reset mid-transaction aborts it: no m_ready, s_req drops on the following edge.
- FSM states IDLE, WAIT, RESP.
- IDLE, m_req=1:
  - Latch m_write, m_addr, m_wdata.
  - Mapped means address bits above REGION_BITS+SELW-1 are all 0 and index < NSLAVE.
  - Mapped -> WAIT. Unmapped -> RESP with error.
- WAIT:
  - s_req[idx]=1, held until ack.
  - On s_ack[idx]=1: capture s_rdata slice idx (zero for writes), go to RESP.
  - Acks from non-selected slaves are ignored.
- RESP:
  - m_ready=1 for exactly one cycle.
  - m_err=1 on error, and then m_rdata=0.
  - s_req=0. Next state IDLE.
- m_req outside IDLE is ignored and not queued. The master re-issues after m_ready.
- s_ack in IDLE or RESP is ignored.
- Minimum latency, ack in the first WAIT cycle:
  - Cycle 0: m_req sampled.
  - Cycle 1: s_req high, s_ack high.
  - Cycle 2: m_ready.
- Unmapped latency: m_ready in cycle 1.
- Back-to-back: with m_req held high, the next request is accepted in the cycle after RESP (IDLE).
- Error register:
  - On any error response, err_flag<=1 and err_addr<=latched address, set in the RESP cycle.
  - err_clr=1 clears err_flag (err_addr retained). If err_clr coincides with a new error, the set wins.
- Width rule: s_addr = latched address masked to REGION_BITS bits. No other truncation.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to WAIT and incremented each WAIT cycle without a valid ack.
  - When the count reaches TIMEOUT with no ack, go to RESP with error, drop s_req, and record err_addr.
  - An ack in the same cycle the count reaches TIMEOUT wins: normal response, no error.
- Not defined: no counter is built, and WAIT holds indefinitely until ack.

Test Plan:
- Read of slave 1 at 0x0010_0040, slave 1 acks in its first WAIT cycle with 0xCAFE_0001 -> s_addr=0x40, s_req=3'b010, m_ready in cycle 2, m_rdata=0xCAFE_0001, m_err=0.
- Write of 0x1234_5678 to 0x0000_0008, slave 0 acks after 5 WAIT cycles -> s_req held 5 cycles, s_wdata=0x1234_5678, s_write=1, m_ready once, m_rdata=0.
- Read of 0x0030_0000 (index 3, NSLAVE=3) -> no s_req, m_ready in cycle 1, m_err=1, err_flag=1, err_addr=0x0030_0000. Then err_clr -> err_flag=0, err_addr unchanged.
- During WAIT for slave 2, slave 0 acks, then slave 2 acks with 0xA5A5_A5A5 -> slave 0 ack ignored, m_rdata=0xA5A5_A5A5.
- nrst=0 in WAIT -> next edge: all outputs 0, state IDLE. A new request after release completes normally.
- BUS_TIMEOUT_EN defined, TIMEOUT=4, slave never acks -> m_ready with m_err=1 after 4 WAIT cycles. Not defined -> no m_ready after 1000 cycles.
